// File: rtl/oldland_dbus_arbiter.sv
// Oldland data-bus arbiter: shares one data bus between the CPU memory stage
// (m0) and the debug controller (m1) with round-robin arbitration.
//
// Optional feature: define OLDLAND_DBUS_TIMEOUT_EN to enable a bus timeout that
// returns an error to the owner after TIMEOUT_CYCLES BUSY cycles without a
// response. Without the macro a transaction waits indefinitely for d_ack/d_error.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | bus free; outputs zero; next requester wins on the next edge
// BUSY  | owner's request driven on the bus, waiting for d_ack/d_error
module oldland_dbus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_access,
  input  logic [31:0] m0_addr,
  input  logic        m0_wr_en,
  input  logic [3:0]  m0_bytesel,
  input  logic [31:0] m0_wr_val,
  output logic [31:0] m0_data,
  output logic        m0_ack,
  output logic        m0_error,

  input  logic        m1_access,
  input  logic [31:0] m1_addr,
  input  logic        m1_wr_en,
  input  logic [3:0]  m1_bytesel,
  input  logic [31:0] m1_wr_val,
  output logic [31:0] m1_data,
  output logic        m1_ack,
  output logic        m1_error,

  output logic [31:0] d_addr,
  output logic [3:0]  d_bytesel,
  output logic        d_wr_en,
  output logic [31:0] d_wr_val,
  output logic        d_access,
  input  logic [31:0] d_data,
  input  logic        d_ack,
  input  logic        d_error,

  output logic [1:0]  grant
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state_q, state_d;
  // 0 = m0, 1 = m1
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   busy;
  logic   expire;
  logic   resp_ack;
  logic   resp_err;

  assign busy = (state_q == BUSY);

`ifdef OLDLAND_DBUS_TIMEOUT_EN
  // Expiry is flagged on the cycle the incremented count would reach the limit,
  // so the error lands in the TIMEOUT_CYCLES-th BUSY cycle.
  localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  assign expire = busy && (cnt_q == TC_LAST);

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign expire             = 1'b0;
`endif

  // Load data is broadcast; only the ack/error strobes are qualified.
  assign m0_data = d_data;
  assign m1_data = d_data;

  // Error beats ack on a collision; a same-cycle ack beats a timeout expiry.
  assign resp_err = busy && (d_error || (expire && !d_ack));
  assign resp_ack = busy && d_ack && !d_error;

  // State, owner and last-winner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic: arbitration in IDLE, completion/timeout in BUSY.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef OLDLAND_DBUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (m0_access || m1_access) begin
          state_d = BUSY;
          owner_d = (m0_access && m1_access) ? !last_q : m1_access;
          last_d  = owner_d;
`ifdef OLDLAND_DBUS_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      BUSY: begin
`ifdef OLDLAND_DBUS_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (resp_ack || resp_err) begin
          state_d = IDLE;
`ifdef OLDLAND_DBUS_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus mux and response steering; everything is zero while IDLE.
  always_comb begin
    d_access  = 1'b0;
    d_addr    = 32'd0;
    d_bytesel = 4'd0;
    d_wr_en   = 1'b0;
    d_wr_val  = 32'd0;
    grant     = 2'b00;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_error  = 1'b0;
    m1_error  = 1'b0;
    if (busy) begin
      d_access = 1'b1;
      if (owner_q) begin
        d_addr    = m1_addr;
        d_bytesel = m1_bytesel;
        d_wr_en   = m1_wr_en;
        d_wr_val  = m1_wr_val;
        grant     = 2'b10;
        m1_ack    = resp_ack;
        m1_error  = resp_err;
      end else begin
        d_addr    = m0_addr;
        d_bytesel = m0_bytesel;
        d_wr_en   = m0_wr_en;
        d_wr_val  = m0_wr_val;
        grant     = 2'b01;
        m0_ack    = resp_ack;
        m0_error  = resp_err;
      end
    end
  end

endmodule

// File: doc/oldland_dbus_arbiter.md
OLDLAND_DBUS_ARBITER -- requirements
Module: oldland_dbus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, number of BUSY cycles without d_ack/d_error before a bus timeout (range 2..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 m0_access/m1_access  input  1  master request (m0 = CPU memory stage, m1 = debug controller); held high until ack/error.
REQ-005 m0_addr/m1_addr  input  32  word-aligned address.
REQ-006 m0_wr_en/m1_wr_en  input  1  1 = store, 0 = load.
REQ-007 m0_bytesel/m1_bytesel  input  4  byte enables.
REQ-008 m0_wr_val/m1_wr_val  input  32  store data.
REQ-009 m0_data/m1_data  output  32  load data, equal to d_data unconditionally.
REQ-010 m0_ack/m1_ack  output  1  completion strobe to owning master.
REQ-011 m0_error/m1_error  output  1  bus-error strobe to owning master.
REQ-012 d_addr, d_bytesel, d_wr_en, d_wr_val  output  32/4/1/32  shared data bus, muxed from owner; all zero when IDLE.
REQ-013 d_access  output  1  bus request, high only in BUSY.
REQ-014 d_data  input  32, d_ack  input  1, d_error  input  1  bus responses.
REQ-015 grant  output  2  one-hot owner ({m1,m0}), 2'b00 when IDLE.

Function
REQ-016 FSM states SHALL be IDLE and BUSY; owner and last-winner SHALL be registered.
REQ-017 In IDLE, any mN_access high SHALL move to BUSY next edge with that master as owner.
REQ-018 Both requesting in IDLE: winner SHALL be the master not granted last (round-robin); after reset m0 wins first.
REQ-019 In BUSY, d_access SHALL be 1 and bus outputs SHALL follow the owner combinationally; non-owner inputs ignored.
REQ-020 d_ack in BUSY SHALL pulse owner's mN_ack same cycle (combinational) and return to IDLE next edge.
REQ-021 d_error in BUSY SHALL pulse owner's mN_error same cycle and return to IDLE; d_ack and d_error together: error forwarded, ack suppressed.
REQ-022 Minimum spacing: one IDLE cycle between transactions; request-to-d_access latency exactly 1 cycle.
REQ-023 Non-owner ack/error SHALL stay 0 at all times; d_ack/d_error in IDLE SHALL be ignored.
REQ-024 Owner dropping mN_access while BUSY is illegal; arbiter SHALL keep d_access high until response.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, grant=0, d_access=0, d_addr/d_bytesel/d_wr_en/d_wr_val=0, all mN_ack/mN_error=0, timeout counter=0, last-winner=m1.
REQ-026 Reset during BUSY SHALL abandon the transaction without any ack/error pulse.

Configuration
REQ-027 Macro OLDLAND_DBUS_TIMEOUT_EN defined: 8-bit counter clears on entering BUSY, increments each BUSY cycle; when it reaches TIMEOUT_CYCLES with no d_ack/d_error, owner's mN_error SHALL pulse that cycle and FSM returns to IDLE; d_ack on the expiry cycle wins (ack, no error).
REQ-028 Macro undefined: no counter; BUSY persists until d_ack or d_error.

Verification
REQ-029 m0 load 0x0000_1000, d_ack 3 cycles after d_access, d_data=0xDEADBEEF -> m0_ack 1 cycle, m0_data=0xDEADBEEF, grant 01 then 00.
REQ-030 m0 and m1 request same cycle after reset, both held -> m0 served first, m1 granted after one IDLE cycle, then m0 again.
REQ-031 m1 store addr 0x10, bytesel 4'b0100, wr_val 0x00AB0000 -> d_wr_en=1 and bus matches exactly; m0_ack stays 0.
REQ-032 d_ack and d_error same cycle during m0 owner -> m0_error=1, m0_ack=0, IDLE next cycle.
REQ-033 OLDLAND_DBUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no response -> m0_error pulses on 4th BUSY cycle, d_access low next; undefined: d_access held 100 cycles.
REQ-034 rst_n low mid-BUSY -> d_access, grant 0 asynchronously; no ack/error; m0 wins first after release.
